// File: rtl/dvi_timing_gen.sv
// DVI/VGA raster timing generator: waits for transmitter setup, then sweeps
// (h_cnt, v_cnt) and emits registered sync, data-enable and pixel coordinates.
module dvi_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iic_done,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        frame_start,
    output logic        running
);

    // state | meaning
    // IDLE  | waiting for iic_done; outputs parked
    // ARM   | one cycle, clears counters
    // RUN   | raster sweep; leaves only at the last pixel of a frame
    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_IDLE  = ~SYNC_POL;

    state_t      state, state_next;
    logic [10:0] h_cnt, v_cnt, h_next, v_next;
    logic        last_pixel, visible, hs_act, vs_act, origin;

    assign last_pixel = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign visible    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_act     = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_act     = (v_cnt >= VS_START) && (v_cnt < VS_END);
    assign origin     = (h_cnt == 11'd0) && (v_cnt == 11'd0);

    always_comb begin
        state_next = state;
        h_next     = h_cnt;
        v_next     = v_cnt;
        case (state)
            IDLE: begin
                if (iic_done) state_next = ARM;
            end
            ARM: begin
                state_next = RUN;
                h_next     = 11'd0;
                v_next     = 11'd0;
            end
            RUN: begin
                if (h_cnt == H_LAST) begin
                    h_next = 11'd0;
                    v_next = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
                end else begin
                    h_next = h_cnt + 11'd1;
                end
                // A low iic_done is only honoured at the frame boundary, so a
                // re-rise before then cancels the stop.
                if (last_pixel && !iic_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            h_cnt       <= 11'd0;
            v_cnt       <= 11'd0;
            de          <= 1'b0;
            x           <= 11'd0;
            y           <= 11'd0;
            frame_start <= 1'b0;
            running     <= 1'b0;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
        end else begin
            state   <= state_next;
            h_cnt   <= h_next;
            v_cnt   <= v_next;
            running <= (state_next == RUN);
            if (state == RUN) begin
                de          <= visible;
                x           <= visible ? h_cnt : 11'd0;
                y           <= visible ? v_cnt : 11'd0;
                frame_start <= origin;
                hsync       <= hs_act ? SYNC_POL : SYNC_IDLE;
                vsync       <= vs_act ? SYNC_POL : SYNC_IDLE;
            end else begin
                de          <= 1'b0;
                x           <= 11'd0;
                y           <= 11'd0;
                frame_start <= 1'b0;
                hsync       <= SYNC_IDLE;
                vsync       <= SYNC_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Directed bench: default VGA instance for startup/line checks, a scaled
// instance for whole-frame, stop and reset behaviour, and a tiny positive-sync one.
module tb_dvi_timing_gen;

    localparam int BHA = 40, BHF = 8, BHS = 12, BHB = 6;
    localparam int BVA = 30, BVF = 5, BVS = 2, BVB = 3;
    localparam int BH  = BHA + BHF + BHS + BHB;
    localparam int BV  = BVA + BVF + BVS + BVB;
    localparam int BF  = BH * BV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic iic_done = 1'b0;

    logic a_hsync, a_vsync, a_de, a_fs, a_run;
    logic b_hsync, b_vsync, b_de, b_fs, b_run;
    logic c_hsync, c_vsync, c_de, c_fs, c_run;
    logic [10:0] a_x, a_y, b_x, b_y, c_x, c_y;

    int comps = 0;
    int errs  = 0;

    always #5 clk = ~clk;

    dvi_timing_gen u_a (
        .clk(clk), .reset(reset), .iic_done(iic_done),
        .hsync(a_hsync), .vsync(a_vsync), .de(a_de), .x(a_x), .y(a_y),
        .frame_start(a_fs), .running(a_run)
    );

    dvi_timing_gen #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB), .SYNC_POL(1'b0)
    ) u_b (
        .clk(clk), .reset(reset), .iic_done(iic_done),
        .hsync(b_hsync), .vsync(b_vsync), .de(b_de), .x(b_x), .y(b_y),
        .frame_start(b_fs), .running(b_run)
    );

    dvi_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) u_c (
        .clk(clk), .reset(reset), .iic_done(iic_done),
        .hsync(c_hsync), .vsync(c_vsync), .de(c_de), .x(c_x), .y(c_y),
        .frame_start(c_fs), .running(c_run)
    );

    // {de, frame_start, running, hsync, vsync, x, y}
    function automatic logic [26:0] vec(input logic d, f, r, h, v, input logic [10:0] xx, yy);
        return {d, f, r, h, v, xx, yy};
    endfunction

    task automatic wait_fs(input int sel, input string name);
        int  n;
        logic fs;
        n  = 0;
        fs = (sel == 0) ? a_fs : (sel == 1) ? b_fs : c_fs;
        while (!fs && n < 6000) begin
            @(negedge clk);
            n++;
            fs = (sel == 0) ? a_fs : (sel == 1) ? b_fs : c_fs;
        end
        comps++;
        if (!fs) begin
            errs++;
            $display("FAIL %s: frame_start got 0 expected 1 within 6000 cycles", name);
        end
    endtask

    task automatic test_reset();
        logic [26:0] idle_lo, idle_hi;
        idle_lo = vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 11'd0);
        idle_hi = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
        repeat (3) @(negedge clk);
        comps++;
        if (vec(a_de, a_fs, a_run, a_hsync, a_vsync, a_x, a_y) !== idle_lo) begin
            errs++;
            $display("FAIL reset_a: got %h expected %h", vec(a_de, a_fs, a_run, a_hsync, a_vsync, a_x, a_y), idle_lo);
        end
        comps++;
        if (vec(c_de, c_fs, c_run, c_hsync, c_vsync, c_x, c_y) !== idle_hi) begin
            errs++;
            $display("FAIL reset_c: got %h expected %h", vec(c_de, c_fs, c_run, c_hsync, c_vsync, c_x, c_y), idle_hi);
        end
        reset = 1'b0;
        repeat (6) @(negedge clk);
        comps++;
        if (vec(b_de, b_fs, b_run, b_hsync, b_vsync, b_x, b_y) !== idle_lo) begin
            errs++;
            $display("FAIL idle_wait_b: got %h expected %h", vec(b_de, b_fs, b_run, b_hsync, b_vsync, b_x, b_y), idle_lo);
        end
    endtask

    task automatic test_startup();
        iic_done = 1'b1;
        @(negedge clk);
        comps++;
        if (a_run !== 1'b0) begin
            errs++;
            $display("FAIL start_arm: running got %b expected 0", a_run);
        end
        @(negedge clk);
        comps++;
        if ({a_run, a_de, a_fs} !== 3'b100) begin
            errs++;
            $display("FAIL start_run: {running,de,fs} got %b expected 100", {a_run, a_de, a_fs});
        end
        @(negedge clk);
        comps++;
        if (vec(a_de, a_fs, a_run, a_hsync, a_vsync, a_x, a_y) !== vec(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 11'd0, 11'd0)) begin
            errs++;
            $display("FAIL start_first_pixel_a: got %h", vec(a_de, a_fs, a_run, a_hsync, a_vsync, a_x, a_y));
        end
        comps++;
        if ({b_fs, b_de, c_fs, c_de} !== 4'b1111) begin
            errs++;
            $display("FAIL start_first_pixel_bc: got %b expected 1111", {b_fs, b_de, c_fs, c_de});
        end
    endtask

    // A is sitting on pixel (0,0) of its first frame.
    task automatic test_line0();
        int de_n, x_err, first_low, hs_n, vs_err;
        de_n = 0; x_err = 0; first_low = -1; hs_n = 0; vs_err = 0;
        for (int i = 0; i < 800; i++) begin
            if (a_de) de_n++;
            if (a_de && (a_x !== 11'(i) || a_y !== 11'd0)) x_err++;
            if (!a_de && (a_x !== 11'd0 || a_y !== 11'd0)) x_err++;
            if (!a_hsync) begin
                hs_n++;
                if (first_low < 0) first_low = i;
            end
            if (a_vsync !== 1'b1) vs_err++;
            @(negedge clk);
        end
        comps++;
        if (de_n != 640) begin errs++; $display("FAIL line0_de: got %0d expected 640", de_n); end
        comps++;
        if (x_err != 0) begin errs++; $display("FAIL line0_xy: got %0d bad samples expected 0", x_err); end
        comps++;
        if (first_low != 656) begin errs++; $display("FAIL line0_hs_start: got %0d expected 656", first_low); end
        comps++;
        if (hs_n != 96) begin errs++; $display("FAIL line0_hs_width: got %0d expected 96", hs_n); end
        comps++;
        if (vs_err != 0) begin errs++; $display("FAIL line0_vsync: got %0d low samples expected 0", vs_err); end
        comps++;
        if ({a_de, a_fs, a_x, a_y} !== {1'b1, 1'b0, 11'd0, 11'd1}) begin
            errs++;
            $display("FAIL line1_start: got de=%b fs=%b x=%0d y=%0d expected 1 0 0 1", a_de, a_fs, a_x, a_y);
        end
    endtask

    task automatic test_frame();
        int de_n, fs_n, hs_n, falls, bad_fall, vs_err;
        logic prev_hs;
        de_n = 0; fs_n = 0; hs_n = 0; falls = 0; bad_fall = 0; vs_err = 0;
        wait_fs(1, "frame_b_anchor");
        prev_hs = 1'b1;
        for (int i = 0; i < BF; i++) begin
            if (b_de) de_n++;
            if (b_fs) fs_n++;
            if (!b_hsync) hs_n++;
            if (prev_hs && !b_hsync) begin
                falls++;
                if (i % BH != BHA + BHF) bad_fall++;
            end
            prev_hs = b_hsync;
            if ((b_vsync == 1'b0) != ((i / BH) >= BVA + BVF && (i / BH) < BVA + BVF + BVS)) vs_err++;
            @(negedge clk);
        end
        comps++;
        if (de_n != BHA * BVA) begin errs++; $display("FAIL frame_de: got %0d expected %0d", de_n, BHA * BVA); end
        comps++;
        if (fs_n != 1) begin errs++; $display("FAIL frame_fs_count: got %0d expected 1", fs_n); end
        comps++;
        if (hs_n != BHS * BV) begin errs++; $display("FAIL frame_hs_total: got %0d expected %0d", hs_n, BHS * BV); end
        comps++;
        if (falls != BV || bad_fall != 0) begin
            errs++;
            $display("FAIL frame_lines: got %0d hsync falls (%0d misplaced) expected %0d", falls, bad_fall, BV);
        end
        comps++;
        if (vs_err != 0) begin errs++; $display("FAIL frame_vsync_lines: got %0d bad samples expected 0", vs_err); end
        comps++;
        if (b_fs !== 1'b1) begin errs++; $display("FAIL frame_period: fs got %b expected 1 after %0d clocks", b_fs, BF); end
    endtask

    task automatic test_tiny_pol();
        int hs_err, vs_err, de_err, fs_n;
        hs_err = 0; vs_err = 0; de_err = 0; fs_n = 0;
        wait_fs(2, "tiny_anchor");
        for (int i = 0; i < 98; i++) begin
            if (c_hsync !== ((i % 14) >= 10 && (i % 14) <= 11)) hs_err++;
            if (c_vsync !== ((i / 14) == 5)) vs_err++;
            if (c_de !== ((i % 14) < 8 && (i / 14) < 4)) de_err++;
            if (c_fs) fs_n++;
            @(negedge clk);
        end
        comps++;
        if (hs_err != 0) begin errs++; $display("FAIL tiny_hsync: got %0d bad samples expected 0", hs_err); end
        comps++;
        if (vs_err != 0) begin errs++; $display("FAIL tiny_vsync: got %0d bad samples expected 0", vs_err); end
        comps++;
        if (de_err != 0) begin errs++; $display("FAIL tiny_de: got %0d bad samples expected 0", de_err); end
        comps++;
        if (fs_n != 1 || c_fs !== 1'b1) begin
            errs++;
            $display("FAIL tiny_frame: got %0d fs in frame, next fs=%b expected 1 and 1", fs_n, c_fs);
        end
    endtask

    task automatic test_drop();
        int fs_n, run_n;
        fs_n = 0; run_n = 0;
        wait_fs(1, "drop_anchor");
        repeat (10 * BH) @(negedge clk);
        iic_done = 1'b0;
        repeat (BF - 2 - 10 * BH) @(negedge clk);
        comps++;
        if (b_run !== 1'b1) begin errs++; $display("FAIL drop_penultimate: running got %b expected 1", b_run); end
        @(negedge clk);
        comps++;
        if ({b_run, b_de} !== 2'b00) begin
            errs++;
            $display("FAIL drop_last_pixel: {running,de} got %b expected 00", {b_run, b_de});
        end
        @(negedge clk);
        comps++;
        if (vec(b_de, b_fs, b_run, b_hsync, b_vsync, b_x, b_y) !== vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 11'd0)) begin
            errs++;
            $display("FAIL drop_idle: got %h", vec(b_de, b_fs, b_run, b_hsync, b_vsync, b_x, b_y));
        end
        for (int i = 0; i < 300; i++) begin
            if (b_fs) fs_n++;
            if (b_run) run_n++;
            @(negedge clk);
        end
        comps++;
        if (fs_n != 0 || run_n != 0) begin
            errs++;
            $display("FAIL drop_stays_idle: got %0d fs, %0d running cycles expected 0 and 0", fs_n, run_n);
        end
    endtask

    task automatic test_mid_reset();
        iic_done = 1'b1;
        wait_fs(1, "reset_anchor");
        repeat (20 * BH + 20) @(negedge clk);
        comps++;
        if ({b_de, b_x, b_y} !== {1'b1, 11'd20, 11'd20}) begin
            errs++;
            $display("FAIL pre_reset_pos: got de=%b x=%0d y=%0d expected 1 20 20", b_de, b_x, b_y);
        end
        reset = 1'b1;
        @(negedge clk);
        comps++;
        if (vec(b_de, b_fs, b_run, b_hsync, b_vsync, b_x, b_y) !== vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 11'd0)) begin
            errs++;
            $display("FAIL mid_reset_b: got %h", vec(b_de, b_fs, b_run, b_hsync, b_vsync, b_x, b_y));
        end
        comps++;
        if (vec(a_de, a_fs, a_run, a_hsync, a_vsync, a_x, a_y) !== vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 11'd0)) begin
            errs++;
            $display("FAIL mid_reset_a: got %h", vec(a_de, a_fs, a_run, a_hsync, a_vsync, a_x, a_y));
        end
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            comps++;
            if (b_fs !== (k == 3)) begin
                errs++;
                $display("FAIL restart_fs_%0d: got %b expected %b", k, b_fs, (k == 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_line0();
        test_frame();
        test_tiny_pol();
        test_drop();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
        $finish;
    end

endmodule
